// File: rtl/mips_pipe_monitor.sv
// Passive pipeline observer: saturating performance counters plus a
// first-word-fall-through writeback trace FIFO drained over valid/ready.
module mips_pipe_monitor #(
  parameter int CNT_W = 16,
  parameter int DEPTH = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     enable,
  input  logic                     clear,
  input  logic                     stall_in,
  input  logic                     branch_in,
  input  logic                     zero_in,
  input  logic                     regwrite_wb_in,
  input  logic [4:0]               dest_wb_in,
  input  logic [31:0]              write_data_in,
  input  logic [1:0]               op_fa_in,
  input  logic [1:0]               op_fb_in,
  output logic [CNT_W-1:0]         cycle_count,
  output logic [CNT_W-1:0]         stall_count,
  output logic [CNT_W-1:0]         taken_count,
  output logic [CNT_W-1:0]         fwd_count,
  output logic [CNT_W-1:0]         retire_count,
  output logic                     trace_valid,
  input  logic                     trace_ready,
  output logic [36:0]              trace_data,
  output logic [$clog2(DEPTH):0]   trace_level,
  output logic                     trace_overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  // Adds 0..2 and clamps at all-ones; the extra top bit catches any carry-out.
  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [1:0]       inc);
    logic [CNT_W:0] s;
    s = {1'b0, a} + {{(CNT_W-1){1'b0}}, inc};
    return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
  endfunction

  logic [CNT_W-1:0] cycle_q, cycle_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic [CNT_W-1:0] taken_q, taken_d;
  logic [CNT_W-1:0] fwd_q, fwd_d;
  logic [CNT_W-1:0] retire_q, retire_d;
  logic [1:0]       fwd_inc;
  logic             wb_valid;

  assign wb_valid = regwrite_wb_in & (|dest_wb_in);
  assign fwd_inc  = {1'b0, |op_fa_in} + {1'b0, |op_fb_in};

  always_comb begin
    cycle_d  = cycle_q;
    stall_d  = stall_q;
    taken_d  = taken_q;
    fwd_d    = fwd_q;
    retire_d = retire_q;
    if (clear) begin
      cycle_d  = '0;
      stall_d  = '0;
      taken_d  = '0;
      fwd_d    = '0;
      retire_d = '0;
    end else if (enable) begin
      cycle_d  = sat_add(cycle_q, 2'd1);
      stall_d  = sat_add(stall_q, {1'b0, stall_in});
      taken_d  = sat_add(taken_q, {1'b0, branch_in & zero_in});
      fwd_d    = sat_add(fwd_q, fwd_inc);
      retire_d = sat_add(retire_q, {1'b0, wb_valid});
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cycle_q  <= '0;
      stall_q  <= '0;
      taken_q  <= '0;
      fwd_q    <= '0;
      retire_q <= '0;
    end else begin
      cycle_q  <= cycle_d;
      stall_q  <= stall_d;
      taken_q  <= taken_d;
      fwd_q    <= fwd_d;
      retire_q <= retire_d;
    end
  end

  assign cycle_count  = cycle_q;
  assign stall_count  = stall_q;
  assign taken_count  = taken_q;
  assign fwd_count    = fwd_q;
  assign retire_count = retire_q;

  logic [36:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          overflow_q, overflow_d;
  logic          empty, full, push_req, push_ok, pop, drop;

  assign empty    = (level_q == '0);
  assign full     = (level_q == LW'(DEPTH));
  assign push_req = enable & wb_valid;
  assign pop      = ~empty & trace_ready;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign push_ok  = push_req & (~full | pop);
  assign drop     = push_req & full & ~pop;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    overflow_d = overflow_q | drop;
    if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)     rd_ptr_d = rd_ptr_q + AW'(1);
    if (push_ok && !pop)      level_d = level_q + LW'(1);
    else if (pop && !push_ok) level_d = level_q - LW'(1);
    if (clear) overflow_d = 1'b0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage needs no reset: empty pointers make stale entries unreachable.
  always_ff @(posedge clock) begin
    if (!reset && push_ok) mem_q[wr_ptr_q] <= {dest_wb_in, write_data_in};
  end

  assign trace_valid    = ~empty;
  assign trace_data     = empty ? 37'd0 : mem_q[rd_ptr_q];
  assign trace_level    = level_q;
  assign trace_overflow = overflow_q;

endmodule

// File: tb/tb_mips_pipe_monitor.sv
// Randomized and directed bench for mips_pipe_monitor; a queue-based model
// (16-bit and 4-bit counter instances) is compared against the DUTs every cycle.
module tb_mips_pipe_monitor;

  localparam int DEPTH = 8;

  logic        clock = 1'b0;
  logic        reset, enable, clear, stall_in, branch_in, zero_in, regwrite;
  logic [4:0]  dest;
  logic [31:0] wdata;
  logic [1:0]  fa, fb;
  logic        ready;

  logic [15:0] a_cyc, a_stl, a_tkn, a_fwd, a_ret;
  logic [3:0]  b_cyc, b_stl, b_tkn, b_fwd, b_ret;
  logic        a_valid, b_valid, a_ovf, b_ovf;
  logic [36:0] a_data, b_data;
  logic [3:0]  a_level, b_level;

  int checks = 0;
  int errors = 0;
  bit chk_en = 0;

  always #5 clock = ~clock;

  mips_pipe_monitor #(.CNT_W(16), .DEPTH(DEPTH)) dut_a (
    .clock(clock), .reset(reset), .enable(enable), .clear(clear),
    .stall_in(stall_in), .branch_in(branch_in), .zero_in(zero_in),
    .regwrite_wb_in(regwrite), .dest_wb_in(dest), .write_data_in(wdata),
    .op_fa_in(fa), .op_fb_in(fb),
    .cycle_count(a_cyc), .stall_count(a_stl), .taken_count(a_tkn),
    .fwd_count(a_fwd), .retire_count(a_ret),
    .trace_valid(a_valid), .trace_ready(ready), .trace_data(a_data),
    .trace_level(a_level), .trace_overflow(a_ovf));

  mips_pipe_monitor #(.CNT_W(4), .DEPTH(DEPTH)) dut_b (
    .clock(clock), .reset(reset), .enable(enable), .clear(clear),
    .stall_in(stall_in), .branch_in(branch_in), .zero_in(zero_in),
    .regwrite_wb_in(regwrite), .dest_wb_in(dest), .write_data_in(wdata),
    .op_fa_in(fa), .op_fb_in(fb),
    .cycle_count(b_cyc), .stall_count(b_stl), .taken_count(b_tkn),
    .fwd_count(b_fwd), .retire_count(b_ret),
    .trace_valid(b_valid), .trace_ready(ready), .trace_data(b_data),
    .trace_level(b_level), .trace_overflow(b_ovf));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: counters[k][0..4] = cycle, stall, taken, fwd, retire for instance k.
  int unsigned     mc [2][5];
  int unsigned     cmax [2] = '{65535, 15};
  logic [36:0]     mq [$];
  bit              movf;

  function automatic int unsigned sat(input int unsigned v, input int unsigned inc,
                                      input int unsigned mx);
    return (v + inc > mx) ? mx : v + inc;
  endfunction

  always @(posedge clock) begin : model
    bit pop, push, full;
    int unsigned inc [5];
    if (reset) begin
      foreach (mc[k, j]) mc[k][j] = 0;
      mq.delete();
      movf = 0;
    end else begin
      inc[0] = 1;
      inc[1] = stall_in;
      inc[2] = branch_in && zero_in;
      inc[3] = (fa != 0) + (fb != 0);
      inc[4] = regwrite && dest != 0;
      for (int k = 0; k < 2; k++)
        for (int j = 0; j < 5; j++)
          if (clear) mc[k][j] = 0;
          else if (enable) mc[k][j] = sat(mc[k][j], inc[j], cmax[k]);
      pop  = mq.size() > 0 && ready;
      push = enable && regwrite && dest != 0;
      full = mq.size() == DEPTH;
      if (push && full && !pop) movf = 1;
      if (pop) void'(mq.pop_front());
      if (push && (!full || pop)) mq.push_back({dest, wdata});
      if (clear) movf = 0;
    end
  end

  always @(negedge clock) begin
    if (chk_en) begin
      chk("a_cycle",  a_cyc, mc[0][0]);
      chk("a_stall",  a_stl, mc[0][1]);
      chk("a_taken",  a_tkn, mc[0][2]);
      chk("a_fwd",    a_fwd, mc[0][3]);
      chk("a_retire", a_ret, mc[0][4]);
      chk("b_cycle",  b_cyc, mc[1][0]);
      chk("b_stall",  b_stl, mc[1][1]);
      chk("b_taken",  b_tkn, mc[1][2]);
      chk("b_fwd",    b_fwd, mc[1][3]);
      chk("b_retire", b_ret, mc[1][4]);
      chk("a_valid",  a_valid, mq.size() != 0);
      chk("a_level",  a_level, mq.size());
      chk("a_data",   a_data, mq.size() != 0 ? mq[0] : 37'd0);
      chk("a_ovf",    a_ovf, movf);
      chk("b_level",  b_level, mq.size());
      chk("b_data",   b_data, mq.size() != 0 ? mq[0] : 37'd0);
      chk("b_ovf",    b_ovf, movf);
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clock);
      @(negedge clock);
    end
  endtask

  task automatic idle();
    clear = 0; stall_in = 0; branch_in = 0; zero_in = 0;
    regwrite = 0; dest = 0; wdata = 0; fa = 0; fb = 0; ready = 0;
  endtask

  initial begin
    reset = 1; enable = 0;
    idle();
    tick(2);
    chk_en = 1;
    chk("rst_level", a_level, 0);
    chk("rst_valid", a_valid, 0);

    // Idle counting
    reset = 0; enable = 1;
    tick(10);
    chk("t1_cycle", a_cyc, 10);
    chk("t1_stall", a_stl, 0);
    chk("t1_valid", a_valid, 0);

    // Stall, branch and forwarding events
    stall_in = 1; tick(3); stall_in = 0;
    branch_in = 1; zero_in = 1; tick(1);
    zero_in = 0; tick(1); branch_in = 0;
    fa = 2; fb = 1; tick(1); fa = 0; fb = 0;
    chk("t2_stall", a_stl, 3);
    chk("t2_taken", a_tkn, 1);
    chk("t2_fwd",   a_fwd, 2);
    chk("t2_cycle", a_cyc, 16);

    // Writebacks, $0 filtered
    regwrite = 1;
    dest = 8; wdata = 32'h11; tick(1);
    dest = 0; wdata = 32'h22; tick(1);
    dest = 9; wdata = 32'h33; tick(1);
    regwrite = 0; dest = 0;
    chk("t3_retire", a_ret, 2);
    chk("t3_level",  a_level, 2);
    chk("t3_head0",  a_data, {5'd8, 32'h11});
    ready = 1; tick(1);
    chk("t3_head1",  a_data, {5'd9, 32'h33});
    tick(1);
    chk("t3_empty",  a_valid, 0);
    ready = 0;

    // Overfill, drain in order
    regwrite = 1;
    for (int i = 0; i < 10; i++) begin
      dest = 5'(i + 1); wdata = 32'(100 + i); tick(1);
    end
    regwrite = 0;
    chk("t4_level", a_level, 8);
    chk("t4_ovf",   a_ovf, 1);
    ready = 1;
    for (int i = 0; i < 8; i++) begin
      chk("t4_drain", a_data, {5'(i + 1), 32'(100 + i)});
      tick(1);
    end
    chk("t4_drained", a_level, 0);
    ready = 0;
    clear = 1; tick(1); clear = 0;
    regwrite = 1;
    for (int i = 0; i < 8; i++) begin
      dest = 5'(i + 1); wdata = 32'(200 + i); tick(1);
    end
    chk("t4_refull", a_level, 8);
    dest = 20; wdata = 32'd300; ready = 1; tick(1);
    regwrite = 0; ready = 0;
    chk("t4_pp_level", a_level, 8);
    chk("t4_pp_ovf",   a_ovf, 0);
    chk("t4_pp_head",  a_data, {5'd2, 32'd201});

    // Saturation on the 4-bit instance
    clear = 1; tick(1); clear = 0;
    fa = 1; fb = 1; tick(7);
    chk("t5_bfwd14", b_fwd, 14);
    tick(1);
    chk("t5_bfwd15", b_fwd, 15);
    chk("t5_afwd16", a_fwd, 16);
    fa = 3; fb = 0; tick(1); fa = 0;
    chk("t5_bfwd_hold", b_fwd, 15);
    tick(20);
    chk("t5_bcycle", b_cyc, 15);

    // Clear with FIFO content, then reset mid-drain
    regwrite = 1; dest = 5; wdata = 32'h55; tick(1); regwrite = 0;
    chk("t6_ovf", a_ovf, 1);
    ready = 1; tick(5); ready = 0;
    chk("t6_level3", a_level, 3);
    clear = 1; stall_in = 1; fa = 1; tick(1);
    idle();
    chk("t6_clr_cycle", a_cyc, 0);
    chk("t6_clr_fwd",   a_fwd, 0);
    chk("t6_clr_ovf",   a_ovf, 0);
    chk("t6_clr_level", a_level, 3);
    ready = 1; tick(1);
    reset = 1; tick(1);
    chk("t6_rst_level", a_level, 0);
    chk("t6_rst_valid", a_valid, 0);
    chk("t6_rst_data",  a_data, 0);
    chk("t6_rst_cycle", a_cyc, 0);
    reset = 0; ready = 0;

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      reset     = ($urandom_range(0, 199) == 0);
      clear     = ($urandom_range(0, 49) == 0);
      enable    = ($urandom_range(0, 9) != 0);
      stall_in  = $urandom_range(0, 1);
      branch_in = $urandom_range(0, 1);
      zero_in   = $urandom_range(0, 1);
      regwrite  = ($urandom_range(0, 9) < 6);
      dest      = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
      wdata     = $urandom;
      fa        = 2'($urandom);
      fb        = 2'($urandom);
      ready     = ($urandom_range(0, 9) < 4);
      tick(1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mips_pipe_monitor.md
Name: mips_pipe_monitor

Overview:
- Passive observer that sits directly downstream of the pipelined MIPS core's debug/status outputs and consumes them every cycle.
- Accumulates saturating performance counters: cycles, stalls, taken branches, forwarded operands and retired writebacks.
- Captures a writeback trace into a small FIFO, drained by the bench or a host through a valid/ready port.
- Never drives the core. Purely an observer for debug and grading.

Parameters:
- CNT_W, 16: width of every performance counter.
- DEPTH, 8: trace FIFO entries. Must be a power of two, at least 2.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  when 0, counters hold and no trace pushes occur.
- clear  in  1  synchronous clear of counters and overflow flag.
- stall_in  in  1  core stall indication.
- branch_in  in  1  branch instruction resolving this cycle.
- zero_in  in  1  ALU zero flag for the resolving branch.
- regwrite_wb_in  in  1  register write in the WB stage.
- dest_wb_in  in  5  WB destination register.
- write_data_in  in  32  WB write data.
- op_fa_in  in  2  forwarding select, operand A (0 means none).
- op_fb_in  in  2  forwarding select, operand B (0 means none).
- cycle_count  out  CNT_W  enabled cycles.
- stall_count  out  CNT_W  enabled cycles with stall_in=1.
- taken_count  out  CNT_W  enabled cycles with branch_in & zero_in.
- fwd_count  out  CNT_W  forwarded operands.
- retire_count  out  CNT_W  writebacks with nonzero dest.
- trace_valid  out  1  FIFO non-empty.
- trace_ready  in  1  consumer accepts the head entry.
- trace_data  out  37  head entry {dest[4:0], data[31:0]}.
- trace_level  out  $clog2(DEPTH)+1  current occupancy.
- trace_overflow  out  1  sticky: a push was dropped.

Behaviour:
- Reset (synchronous, clock edge with reset=1):
  - All counters 0, FIFO empty, trace_valid=0, trace_level=0, trace_overflow=0, trace_data=0.
  - Reset overrides clear, enable and all other inputs.
  - Reset asserted mid-drain discards all FIFO contents.
- Counters update on the edge when enable=1 and clear=0:
  - cycle +1 every such cycle.
  - stall +1 if stall_in=1.
  - taken +1 if branch_in & zero_in.
  - fwd + ((op_fa_in!=0) + (op_fb_in!=0)), so the increment is 0, 1 or 2.
  - retire +1 if regwrite_wb_in & (dest_wb_in!=0).
- Counter saturation: every counter saturates at 2^CNT_W-1 and never wraps. fwd clamps to the maximum when an increment of 2 would exceed it.
- clear=1: counters and trace_overflow go to 0 on the next edge. clear wins over enable in the same cycle. FIFO contents and level are unaffected.
- Trace push condition: enable & regwrite_wb_in & dest_wb_in!=0. stall_in does not block the push. Writes to $0 are never traced or counted.
- Trace pop condition: trace_valid & trace_ready.
- FIFO is first-word fall-through. trace_data is combinationally the head entry whenever trace_valid=1, and is 0 when the FIFO is empty.
  - Push latency: data pushed on edge N is visible with trace_valid=1 in the cycle after edge N.
- trace_level +1 on push only, -1 on pop only, unchanged on simultaneous push and pop.
- Full (level==DEPTH):
  - Push without pop: entry dropped, trace_overflow set to 1, level stays DEPTH.
  - Push with pop: both accepted, level stays DEPTH, no overflow.
- Empty: trace_ready is ignored and there is no underflow. Push and ready in the same cycle is a push only; the entry is presented the next cycle.
- Pointers wrap modulo DEPTH. Order is strict FIFO.
- trace_overflow stays set until reset or clear. If clear and a dropping push occur in the same cycle, the flag is cleared.
- No combinational path from status inputs to any output. All outputs except trace_data/trace_valid are direct register outputs.

Test Plan:
1. Reset, then 10 enabled cycles with all status inputs 0 -> cycle_count=10, all other counters 0, trace_valid=0, trace_level=0.
2. stall_in=1 for 3 cycles; branch_in=1 with zero_in=1 once and with zero_in=0 once; op_fa=2, op_fb=1 for 1 cycle -> stall_count=3, taken_count=1, fwd_count=2.
3. Writebacks (dest=8, 0x11), (dest=0, 0x22), (dest=9, 0x33) with trace_ready=0 -> retire_count=2, trace_level=2; then ready=1 -> pops (8, 0x11) then (9, 0x33), trace_valid=0 afterwards.
4. Ten pushes with ready=0 and DEPTH=8 -> level=8, trace_overflow=1, drain yields the first 8 entries in order; then one push and one pop in the same cycle while full -> level stays 8, no new drop.
5. CNT_W=4, 20 enabled cycles -> cycle_count holds at 15; preload fwd_count to 14, then op_fa=op_fb=1 -> fwd_count=15.
6. clear=1 together with enable=1 while FIFO holds 3 entries -> counters and overflow are 0 next cycle, level stays 3. Then reset mid-drain -> all outputs are at reset values on the next edge.
